// File: rtl/lgn_pkg.sv
// Shared constants for the logic-gate-network classifier input stage.
// Frame geometry, result widths and loader FSM state encodings.
package lgn_pkg;
    localparam int INPUTS        = 256;
    localparam int CATEGORIES    = 10;
    localparam int IDX_W         = 4;
    localparam int VAL_W         = 8;
    localparam int SETTLE_CYCLES = 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;
endpackage

// File: rtl/lgn_frame_loader.sv
// Byte-stream frame assembler with atomic commit; result latched SETTLE_CYCLES+1 edges after commit.
// in_valid is never back-pressured: loading continues during SETTLE, and a commit there sets overrun.
module lgn_frame_loader #(
    parameter  int INPUTS        = lgn_pkg::INPUTS,
    parameter  int SETTLE_CYCLES = lgn_pkg::SETTLE_CYCLES,
    parameter  int IDX_W         = lgn_pkg::IDX_W,
    parameter  int VAL_W         = lgn_pkg::VAL_W,
    localparam int BYTES         = INPUTS / 8,
    localparam int CNT_W         = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    input  logic              in_start,
    output logic [INPUTS-1:0] frame_out,
    output logic              frame_valid,
    input  logic [IDX_W-1:0]  cat_index,
    input  logic [VAL_W-1:0]  cat_value,
    output logic [IDX_W-1:0]  result_index,
    output logic [VAL_W-1:0]  result_value,
    output logic              result_valid,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  byte_cnt
);
    import lgn_pkg::*;

    localparam int SC_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    logic [INPUTS-1:0] shadow_q, shadow_d;
    logic [INPUTS-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   settle_q, settle_d;
    logic [0:0]        state_q, state_d;
    logic              fv_q, fv_d;
    logic              rvld_q, rvld_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [VAL_W-1:0]  rval_q, rval_d;
    logic              ovr_q, ovr_d;
    logic              last_beat;
    logic              commit;

    assign last_beat = in_valid && (cnt_q == CNT_W'(BYTES - 1));
    // A restart on the final beat discards the frame instead of committing it.
    assign commit    = last_beat && !in_start;

    always_comb begin
        shadow_d = shadow_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        state_d  = state_q;
        fv_d     = 1'b0;
        rvld_d   = 1'b0;
        ridx_d   = ridx_q;
        rval_d   = rval_q;
        ovr_d    = ovr_q;

        if (in_start) begin
            shadow_d = '0;
            cnt_d    = '0;
            ovr_d    = 1'b0;
            if (in_valid) begin
                shadow_d[7:0] = in_byte;
                cnt_d         = CNT_W'(1);
            end
        end else if (in_valid) begin
            shadow_d = {shadow_q[INPUTS-9:0], in_byte};
            cnt_d    = last_beat ? '0 : cnt_q + CNT_W'(1);
        end

        // A fresh commit pre-empts any pending capture of the previous frame.
        if (commit) begin
            frame_d  = {shadow_q[INPUTS-9:0], in_byte};
            settle_d = SC_W'(SETTLE_CYCLES);
            state_d  = ST_SETTLE;
            fv_d     = 1'b1;
            if (state_q == ST_SETTLE) begin
                ovr_d = 1'b1;
            end
        end else if (state_q == ST_SETTLE) begin
            if (settle_q == '0) begin
                ridx_d  = cat_index;
                rval_d  = cat_value;
                rvld_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                settle_d = settle_q - SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            frame_q  <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            state_q  <= ST_IDLE;
            fv_q     <= 1'b0;
            rvld_q   <= 1'b0;
            ridx_q   <= '0;
            rval_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            state_q  <= state_d;
            fv_q     <= fv_d;
            rvld_q   <= rvld_d;
            ridx_q   <= ridx_d;
            rval_q   <= rval_d;
            ovr_q    <= ovr_d;
        end
    end

    assign frame_out    = frame_q;
    assign frame_valid  = fv_q;
    assign result_index = ridx_q;
    assign result_value = rval_q;
    assign result_valid = rvld_q;
    assign busy         = (state_q == ST_SETTLE);
    assign overrun      = ovr_q;
    assign byte_cnt     = cnt_q;
endmodule

// File: doc/lgn_frame_loader.md
Name: lgn_frame_loader

Overview:
Upstream input stage for the logic-gate-network classifier. It assembles a 256-bit binarised image from a byte stream into a shadow register and commits the complete frame atomically to the network input. It then waits a fixed settle time for the combinational network, popcount and arg-max path, and latches the winning category index and value into stable result registers. This replaces the free-running 8-bit shift of the input vector with framed, handshaked loading.

Parameters:
INPUTS, 256, frame width in bits; must be a multiple of 8.
SETTLE_CYCLES, 2, cycles between frame commit and result capture; 0 is legal.
IDX_W, 4, width of the category index input/result.
VAL_W, 8, width of the category score input/result.
(derived) BYTES = INPUTS/8; CNT_W = $clog2(BYTES).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_byte  in  8  image byte
in_valid  in  1  accept in_byte this cycle
in_start  in  1  synchronous restart of the frame being assembled
frame_out  out  INPUTS  committed frame, drives the network input
frame_valid  out  1  one-cycle pulse on the cycle after a commit
cat_index  in  IDX_W  arg-max index from the downstream stage
cat_value  in  VAL_W  arg-max score from the downstream stage
result_index  out  IDX_W  latched index
result_value  out  VAL_W  latched score
result_valid  out  1  one-cycle pulse when the result registers update
busy  out  1  high while in SETTLE
overrun  out  1  sticky: a frame was committed while in SETTLE
byte_cnt  out  CNT_W  bytes accepted in the current frame

Behaviour:
- Reset (async, rst_n=0): all registers and outputs go to 0 immediately; state is IDLE. Release is synchronous to clk.
- Shadow register: on in_valid, shadow <= {shadow[INPUTS-9:0], in_byte}. The first byte of a frame lands in frame_out[INPUTS-1:INPUTS-8]; the last byte lands in [7:0].
- byte_cnt increments on each in_valid and wraps BYTES-1 -> 0.
- Commit: on the in_valid beat with byte_cnt==BYTES-1, do all of the following at the same edge E0:
  - frame_out <= {shadow[INPUTS-9:0], in_byte}
  - byte_cnt <= 0
  - settle counter <= SETTLE_CYCLES
  - state <= SETTLE
  - frame_valid is high for the cycle after E0.
- frame_out changes only at a commit and at reset.
- States:
  - IDLE: waits for a commit.
  - SETTLE: the settle counter decrements each cycle. At the edge where it is 0, result_index/result_value <= cat_index/cat_value, result_valid pulses, and state returns to IDLE.
  - Latency: the result edge is E0+SETTLE_CYCLES+1.
- Loading continues during SETTLE (double buffering); in_valid is never back-pressured.
- Commit while in SETTLE: the new frame is committed, the settle counter reloads, and overrun is set. The earlier frame produces no result_valid.
- in_start: byte_cnt and shadow clear to 0 and overrun clears. frame_out, state and the settle counter are unaffected.
- in_start together with in_valid: in_byte becomes byte 0 of the new frame (byte_cnt -> 1).
- in_start on a commit beat: in_start wins and no commit occurs.
- result registers hold until the next capture.
- busy = (state==SETTLE).

Decomposition:
- Shared package lgn_pkg holds INPUTS, CATEGORIES, IDX_W, VAL_W and the state enum (IDLE, SETTLE).
- Single module; no sub-module is needed. The settle timer and byte counter stay inline.

Test Plan:
1. Reset, then 32 back-to-back in_valid bytes 0x00..0x1F, with cat_index=7 and cat_value=0x5A held.
   -> frame_out[255:248]=0x00, [7:0]=0x1F, frame_valid one cycle after the 32nd beat.
   -> result_valid at E0+3 with result_index=7, result_value=0x5A.
2. The same 32 bytes with random 0-3 cycle gaps on in_valid.
   -> identical frame_out; frame_valid only after the 32nd accepted byte; byte_cnt tracks exactly.
3. 10 bytes of 0xFF, then in_start, then 32 bytes of 0xA5.
   -> frame_out = all 0xA5, and the commit occurs after exactly 32 post-start bytes.
4. SETTLE_CYCLES=40 with 64 back-to-back bytes.
   -> second commit at beat 64, overrun=1, exactly one result_valid at 41 cycles after the second commit.
   -> in_start then clears overrun.
5. Drop rst_n mid-SETTLE.
   -> all outputs 0 asynchronously; no result_valid after release; the next 32 bytes commit normally.
6. Assert in_start with in_valid (byte 0x3C), then 31 more bytes.
   -> commit after those 31, with frame_out[255:248]=0x3C.
